// File: rtl/serializer_arbiter.sv
// Round-robin arbiter that forwards one requester word at a time to a serializer and reports completion.
// Optional statistics counters are built when SERIALIZER_ARB_STATS_EN is defined.
module serializer_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int START_TO = 4
) (
  input  logic                       clk_i,
  input  logic                       arst_n_i,
  input  logic [NUM_REQ-1:0]         req_val_i,
  input  logic [NUM_REQ*16-1:0]      req_data_i,
  input  logic [NUM_REQ*4-1:0]       req_mod_i,
  output logic [NUM_REQ-1:0]         req_ack_o,
  output logic                       req_err_o,
  output logic [15:0]                data_o,
  output logic [3:0]                 data_mod_o,
  output logic                       data_val_o,
  input  logic                       busy_i,
  output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
  output logic                       arb_busy_o,
  output logic [15:0]                xfer_cnt_o,
  output logic [7:0]                 err_cnt_o
);

  localparam int IDW = $clog2(NUM_REQ);
  localparam int TOW = $clog2(START_TO + 1);
  localparam logic [TOW-1:0]     TO_LAST  = TOW'(START_TO - 1);
  localparam logic [IDW:0]       NREQ_W   = (IDW + 1)'(NUM_REQ);
  localparam logic [IDW-1:0]     LAST_ID  = IDW'(NUM_REQ - 1);
  localparam logic [NUM_REQ-1:0] ACK_ONE  = NUM_REQ'(1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_START, HOLD, DONE} state_e;

  state_e               state_q, state_d;
  logic [IDW-1:0]       grant_q, grant_d;
  logic [IDW-1:0]       rr_q, rr_d;
  logic [15:0]          data_q, data_d;
  logic [3:0]           mod_q, mod_d;
  logic                 dval_q, dval_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 err_q, err_d;
  logic [TOW-1:0]       to_cnt_q, to_cnt_d;

  logic [15:0]          data_arr [NUM_REQ];
  logic [3:0]           mod_arr  [NUM_REQ];
  logic                 found;
  logic [IDW-1:0]       win;
  logic [IDW:0]         idx_sum;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign data_arr[gi] = req_data_i[16*gi +: 16];
      assign mod_arr[gi]  = req_mod_i[4*gi +: 4];
    end
  endgenerate

  // First active requester at or after rr_q, wrapping past the last index.
  always_comb begin
    found   = 1'b0;
    win     = '0;
    idx_sum = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx_sum = {1'b0, rr_q} + (IDW + 1)'(i);
      if (idx_sum >= NREQ_W) idx_sum = idx_sum - NREQ_W;
      if (!found && req_val_i[idx_sum[IDW-1:0]]) begin
        found = 1'b1;
        win   = idx_sum[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_d     = rr_q;
    data_d   = data_q;
    mod_d    = mod_q;
    to_cnt_d = to_cnt_q;
    dval_d   = 1'b0;
    ack_d    = '0;
    err_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (found && !busy_i) begin
          grant_d = win;
          data_d  = data_arr[win];
          mod_d   = mod_arr[win];
          // Lengths 1 and 2 are not accepted by the serializer; fail them without issuing.
          if (mod_arr[win] == 4'd1 || mod_arr[win] == 4'd2) begin
            state_d = DONE;
            err_d   = 1'b1;
          end else begin
            state_d = ISSUE;
            dval_d  = 1'b1;
          end
        end
      end
      ISSUE: begin
        state_d  = WAIT_START;
        to_cnt_d = '0;
      end
      WAIT_START: begin
        if (busy_i) begin
          state_d = HOLD;
        end else if (to_cnt_q == TO_LAST) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (!busy_i) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        rr_d    = (grant_q == LAST_ID) ? '0 : grant_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // Ack/err are registered on entry so they are high exactly during DONE.
    if (state_d == DONE) ack_d = ACK_ONE << grant_d;
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_q     <= '0;
      data_q   <= '0;
      mod_q    <= '0;
      dval_q   <= 1'b0;
      ack_q    <= '0;
      err_q    <= 1'b0;
      to_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_q     <= rr_d;
      data_q   <= data_d;
      mod_q    <= mod_d;
      dval_q   <= dval_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      to_cnt_q <= to_cnt_d;
    end
  end

  assign req_ack_o  = ack_q;
  assign req_err_o  = err_q;
  assign data_o     = data_q;
  assign data_mod_o = mod_q;
  assign data_val_o = dval_q;
  assign grant_id_o = grant_q;
  assign arb_busy_o = (state_q != IDLE);

`ifdef SERIALIZER_ARB_STATS_EN
  logic [15:0] xfer_q;
  logic [7:0]  errc_q;

  // Counted on the cycle the ack is presented; both saturate.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      xfer_q <= '0;
      errc_q <= '0;
    end else if (state_q == DONE) begin
      if (err_q) begin
        if (errc_q != '1) errc_q <= errc_q + 1'b1;
      end else begin
        if (xfer_q != '1) xfer_q <= xfer_q + 1'b1;
      end
    end
  end

  assign xfer_cnt_o = xfer_q;
  assign err_cnt_o  = errc_q;
`else
  assign xfer_cnt_o = '0;
  assign err_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_serializer_arbiter.sv
// Directed self-checking bench for serializer_arbiter (NUM_REQ=4, START_TO=4).
// Expected statistics depend on whether SERIALIZER_ARB_STATS_EN is defined for the build.
module tb_serializer_arbiter;

`ifdef SERIALIZER_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        arst_n_i = 1'b0;
  logic [3:0]  req_val_i = '0;
  logic [63:0] req_data_i;
  logic [15:0] req_mod_i;
  logic [3:0]  req_ack_o;
  logic        req_err_o;
  logic [15:0] data_o;
  logic [3:0]  data_mod_o;
  logic        data_val_o;
  logic        busy_i = 1'b0;
  logic [1:0]  grant_id_o;
  logic        arb_busy_o;
  logic [15:0] xfer_cnt_o;
  logic [7:0]  err_cnt_o;

  logic [15:0] tb_data [4] = '{16'h0, 16'h0, 16'h0, 16'h0};
  logic [3:0]  tb_mod  [4] = '{4'h0, 4'h0, 4'h0, 4'h0};

  assign req_data_i = {tb_data[3], tb_data[2], tb_data[1], tb_data[0]};
  assign req_mod_i  = {tb_mod[3], tb_mod[2], tb_mod[1], tb_mod[0]};

  serializer_arbiter #(.NUM_REQ(4), .START_TO(4)) dut (
    .clk_i      (clk_i),
    .arst_n_i   (arst_n_i),
    .req_val_i  (req_val_i),
    .req_data_i (req_data_i),
    .req_mod_i  (req_mod_i),
    .req_ack_o  (req_ack_o),
    .req_err_o  (req_err_o),
    .data_o     (data_o),
    .data_mod_o (data_mod_o),
    .data_val_o (data_val_o),
    .busy_i     (busy_i),
    .grant_id_o (grant_id_o),
    .arb_busy_o (arb_busy_o),
    .xfer_cnt_o (xfer_cnt_o),
    .err_cnt_o  (err_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;
  int busy_left = 0;

  int          obs_cycles;
  int          obs_dval;
  logic [3:0]  obs_ack;
  logic        obs_err;
  logic [1:0]  obs_gid;
  logic [15:0] obs_data;
  logic [3:0]  obs_mod;
  logic        obs_stable;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
    if (busy_left > 0) begin
      busy_left--;
      if (busy_left == 0) busy_i = 1'b0;
    end
  endtask

  task automatic do_reset();
    arst_n_i  = 1'b0;
    req_val_i = '0;
    busy_i    = 1'b0;
    busy_left = 0;
    repeat (2) @(posedge clk_i);
    #1;
    arst_n_i = 1'b1;
  endtask

  // Acts as the serializer: raises busy for blen cycles starting the cycle after data_val_o.
  // Returns on the first ack or after max_cyc clocks.
  task automatic run_xfer(input int max_cyc, input int blen);
    int pend;
    pend       = 0;
    obs_cycles = 0;
    obs_dval   = 0;
    obs_ack    = '0;
    obs_err    = 1'b0;
    obs_gid    = '0;
    obs_stable = 1'b1;
    while (obs_cycles < max_cyc) begin
      tick();
      obs_cycles++;
      if (pend != 0) begin
        pend = 0;
        busy_i    = 1'b1;
        busy_left = blen;
      end
      if (data_val_o) begin
        obs_dval++;
        obs_data = data_o;
        obs_mod  = data_mod_o;
        if (blen > 0) pend = 1;
      end else if (arb_busy_o && obs_dval > 0 &&
                   (data_o !== obs_data || data_mod_o !== obs_mod)) begin
        obs_stable = 1'b0;
      end
      if (req_ack_o !== 4'b0000) begin
        obs_ack = req_ack_o;
        obs_err = req_err_o;
        obs_gid = grant_id_o;
        break;
      end
    end
    $display("xfer: gid=%0d ack=%b err=%b dval=%0d data=%h cycles=%0d",
             obs_gid, obs_ack, obs_err, obs_dval, obs_data, obs_cycles);
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (req_ack_o !== 4'b0) begin n_bad++; $display("FAIL reset_ack got=%b exp=0000", req_ack_o); end
    n_cmp++; if (data_val_o !== 1'b0) begin n_bad++; $display("FAIL reset_dval got=%b exp=0", data_val_o); end
    n_cmp++; if (arb_busy_o !== 1'b0) begin n_bad++; $display("FAIL reset_arb_busy got=%b exp=0", arb_busy_o); end
    n_cmp++; if ({data_o, data_mod_o, grant_id_o, req_err_o} !== 23'h0) begin
      n_bad++; $display("FAIL reset_regs got data=%h mod=%h gid=%0d err=%b exp=all 0", data_o, data_mod_o, grant_id_o, req_err_o);
    end
    n_cmp++; if ({xfer_cnt_o, err_cnt_o} !== 24'h0) begin
      n_bad++; $display("FAIL reset_cnt got xfer=%0d err=%0d exp=0/0", xfer_cnt_o, err_cnt_o);
    end
    do_reset();
  endtask

  task automatic test_single();
    tb_data[0] = 16'hA5F0;
    tb_mod[0]  = 4'd0;
    req_val_i  = 4'b0001;
    run_xfer(60, 16);
    n_cmp++; if (obs_dval !== 1) begin n_bad++; $display("FAIL single_dval_count got=%0d exp=1", obs_dval); end
    n_cmp++; if (obs_data !== 16'hA5F0 || obs_mod !== 4'd0) begin
      n_bad++; $display("FAIL single_data got=%h/%h exp=a5f0/0", obs_data, obs_mod);
    end
    n_cmp++; if (obs_ack !== 4'b0001 || obs_err !== 1'b0) begin
      n_bad++; $display("FAIL single_ack got=%b err=%b exp=0001 err=0", obs_ack, obs_err);
    end
    n_cmp++; if (obs_cycles !== 19) begin n_bad++; $display("FAIL single_latency got=%0d exp=19", obs_cycles); end
    n_cmp++; if (obs_stable !== 1'b1) begin n_bad++; $display("FAIL single_hold_stable got=%b exp=1", obs_stable); end
    req_val_i = '0;
    tick();
    n_cmp++; if (arb_busy_o !== 1'b0 || req_ack_o !== 4'b0) begin
      n_bad++; $display("FAIL single_idle got busy=%b ack=%b exp=0/0000", arb_busy_o, req_ack_o);
    end
    tick();
    n_cmp++; if (data_o !== 16'hA5F0 || data_val_o !== 1'b0) begin
      n_bad++; $display("FAIL single_data_hold got=%h dval=%b exp=a5f0 dval=0", data_o, data_val_o);
    end
    n_cmp++; if (xfer_cnt_o !== (STATS ? 16'd1 : 16'd0)) begin
      n_bad++; $display("FAIL single_xfer_cnt got=%0d exp=%0d", xfer_cnt_o, STATS ? 1 : 0);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_id;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      tb_data[k] = 16'h1000 + 16'(k);
      tb_mod[k]  = 4'(k + 3);
    end
    req_val_i = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      exp_id = 2'(n % 4);
      run_xfer(40, 2);
      n_cmp++; if (obs_gid !== exp_id || obs_ack !== (4'b0001 << exp_id) || obs_err !== 1'b0) begin
        n_bad++; $display("FAIL rr_grant_%0d got gid=%0d ack=%b err=%b exp gid=%0d", n, obs_gid, obs_ack, obs_err, exp_id);
      end
      n_cmp++; if (obs_dval !== 1 || obs_data !== (16'h1000 + 16'(exp_id)) || obs_mod !== 4'(exp_id + 3)) begin
        n_bad++; $display("FAIL rr_data_%0d got dval=%0d data=%h mod=%0d exp dval=1 data=%h", n, obs_dval, obs_data, obs_mod, 16'h1000 + 16'(exp_id));
      end
      n_cmp++; if (obs_cycles !== ((n == 0) ? 5 : 6)) begin
        n_bad++; $display("FAIL rr_spacing_%0d got=%0d exp=%0d", n, obs_cycles, (n == 0) ? 5 : 6);
      end
    end
    req_val_i = '0;
    tick();
    n_cmp++; if (xfer_cnt_o !== (STATS ? 16'd5 : 16'd0)) begin
      n_bad++; $display("FAIL rr_xfer_cnt got=%0d exp=%0d", xfer_cnt_o, STATS ? 5 : 0);
    end
  endtask

  task automatic test_mod_error();
    tb_data[2] = 16'hC0DE;
    tb_mod[2]  = 4'd2;
    req_val_i  = 4'b0100;
    run_xfer(10, 4);
    n_cmp++; if (obs_ack !== 4'b0100 || obs_err !== 1'b1 || obs_dval !== 0) begin
      n_bad++; $display("FAIL moderr2_ack got=%b err=%b dval=%0d exp=0100 err=1 dval=0", obs_ack, obs_err, obs_dval);
    end
    n_cmp++; if (obs_cycles !== 1 || data_o !== 16'hC0DE || data_mod_o !== 4'd2) begin
      n_bad++; $display("FAIL moderr2_timing got cycles=%0d data=%h mod=%0d exp=1 c0de 2", obs_cycles, data_o, data_mod_o);
    end
    req_val_i = '0;
    tick();
    tb_mod[3] = 4'd1;
    req_val_i = 4'b1000;
    run_xfer(10, 4);
    n_cmp++; if (obs_ack !== 4'b1000 || obs_err !== 1'b1 || obs_dval !== 0) begin
      n_bad++; $display("FAIL moderr1_ack got=%b err=%b dval=%0d exp=1000 err=1 dval=0", obs_ack, obs_err, obs_dval);
    end
    req_val_i = '0;
    tick();
    n_cmp++; if (err_cnt_o !== (STATS ? 8'd2 : 8'd0)) begin
      n_bad++; $display("FAIL moderr_err_cnt got=%0d exp=%0d", err_cnt_o, STATS ? 2 : 0);
    end
  endtask

  task automatic test_timeout();
    tb_data[1] = 16'h1234;
    tb_mod[1]  = 4'd0;
    req_val_i  = 4'b0010;
    run_xfer(20, 0);
    n_cmp++; if (obs_ack !== 4'b0010 || obs_err !== 1'b1 || obs_dval !== 1) begin
      n_bad++; $display("FAIL timeout_ack got=%b err=%b dval=%0d exp=0010 err=1 dval=1", obs_ack, obs_err, obs_dval);
    end
    n_cmp++; if (obs_cycles !== 6) begin n_bad++; $display("FAIL timeout_latency got=%0d exp=6", obs_cycles); end
    req_val_i = '0;
    tick();
    n_cmp++; if (arb_busy_o !== 1'b0) begin n_bad++; $display("FAIL timeout_idle got=%b exp=0", arb_busy_o); end
    n_cmp++; if (err_cnt_o !== (STATS ? 8'd3 : 8'd0)) begin
      n_bad++; $display("FAIL timeout_err_cnt got=%0d exp=%0d", err_cnt_o, STATS ? 3 : 0);
    end
  endtask

  task automatic test_reset_mid();
    int         bad_cnt;
    logic       got;
    logic [3:0] ack_v;
    logic       err_v;
    tb_data[1] = 16'hBEEF;
    tb_mod[1]  = 4'd8;
    req_val_i  = 4'b0010;
    tick();
    tick();
    busy_i = 1'b1;
    tick();
    tick();
    n_cmp++; if (arb_busy_o !== 1'b1 || data_o !== 16'hBEEF || grant_id_o !== 2'd1) begin
      n_bad++; $display("FAIL midrst_hold got busy=%b data=%h gid=%0d exp=1 beef 1", arb_busy_o, data_o, grant_id_o);
    end
    #2;
    arst_n_i = 1'b0;
    #1;
    n_cmp++; if ({data_o, data_mod_o, grant_id_o, arb_busy_o, data_val_o, req_ack_o} !== 28'h0) begin
      n_bad++; $display("FAIL midrst_async got data=%h mod=%h gid=%0d busy=%b dval=%b ack=%b exp=all 0",
                        data_o, data_mod_o, grant_id_o, arb_busy_o, data_val_o, req_ack_o);
    end
    @(posedge clk_i);
    #1;
    arst_n_i = 1'b1;
    bad_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (data_val_o !== 1'b0 || arb_busy_o !== 1'b0 || req_ack_o !== 4'b0) bad_cnt++;
    end
    n_cmp++; if (bad_cnt !== 0) begin n_bad++; $display("FAIL midrst_no_grant_busy got=%0d bad cycles exp=0", bad_cnt); end
    busy_i = 1'b0;
    tick();
    n_cmp++; if (data_val_o !== 1'b1 || data_o !== 16'hBEEF) begin
      n_bad++; $display("FAIL midrst_regrant got dval=%b data=%h exp=1 beef", data_val_o, data_o);
    end
    got   = 1'b0;
    ack_v = '0;
    err_v = 1'b0;
    for (int c = 0; c < 10 && !got; c++) begin
      tick();
      if (req_ack_o !== 4'b0) begin
        got   = 1'b1;
        ack_v = req_ack_o;
        err_v = req_err_o;
      end
    end
    $display("xfer: gid=1 ack=%b err=%b after reset regrant", ack_v, err_v);
    n_cmp++; if (ack_v !== 4'b0010 || err_v !== 1'b1) begin
      n_bad++; $display("FAIL midrst_ack got=%b err=%b exp=0010 err=1", ack_v, err_v);
    end
    req_val_i = '0;
    tick();
    n_cmp++; if (err_cnt_o !== (STATS ? 8'd1 : 8'd0) || xfer_cnt_o !== 16'd0) begin
      n_bad++; $display("FAIL midrst_cnt got err=%0d xfer=%0d exp=%0d/0", err_cnt_o, xfer_cnt_o, STATS ? 1 : 0);
    end
  endtask

  task automatic test_stats();
    int bad_cnt;
    do_reset();
    tb_data[0] = 16'h5A5A;
    tb_mod[0]  = 4'd0;
    req_val_i  = 4'b0001;
    bad_cnt    = 0;
    for (int n = 0; n < 300; n++) begin
      run_xfer(20, 1);
      if (obs_ack !== 4'b0001 || obs_err !== 1'b0) bad_cnt++;
    end
    n_cmp++; if (bad_cnt !== 0) begin n_bad++; $display("FAIL stats_acks got=%0d bad acks exp=0", bad_cnt); end
    req_val_i = '0;
    tick();
    n_cmp++; if (xfer_cnt_o !== (STATS ? 16'd300 : 16'd0)) begin
      n_bad++; $display("FAIL stats_xfer_cnt got=%0d exp=%0d", xfer_cnt_o, STATS ? 300 : 0);
    end
    n_cmp++; if (err_cnt_o !== 8'd0) begin n_bad++; $display("FAIL stats_err_cnt got=%0d exp=0", err_cnt_o); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_mod_error();
    test_timeout();
    test_reset_mid();
    test_stats();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
